// File: rtl/alu_uart_sequencer.sv
// Frame sequencer between UART rx/tx and the ALU: loads A, B, OP from bytes,
// launches one transmit of the ALU result per frame. Ports: rx byte/strobe in,
// ALU result in, tx done in; ALU operands, tx byte/start, overrun, timeout out.
module alu_uart_sequencer #(
  parameter int NB_DATA    = 8,
  parameter int NB_OP      = 6,
  parameter int TIMEOUT    = 1_000_000,
  parameter int NB_TIMEOUT = 20
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OP-1:0]   o_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_overrun,
  output logic               o_timeout
);

  typedef enum logic [2:0] {
    WAIT_A, WAIT_B, WAIT_OP, EXEC, WAIT_TX
  } state_t;

  localparam logic [NB_TIMEOUT-1:0] CNT_LAST =
    NB_TIMEOUT'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [NB_DATA-1:0]  data_a_q, data_a_d;
  logic [NB_DATA-1:0]  data_b_q, data_b_d;
  logic [NB_OP-1:0]    op_q, op_d;
  logic [NB_DATA-1:0]  tx_data_q, tx_data_d;
  logic                tx_start_q, tx_start_d;
  logic                overrun_q, overrun_d;
  logic                timeout_q, timeout_d;
  logic [NB_TIMEOUT-1:0] cnt_q, cnt_d;
  logic                cnt_last;

  // A strobe on the terminal cycle takes priority over the abort.
  assign cnt_last = (cnt_q == CNT_LAST);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= WAIT_A;
      data_a_q   <= '0;
      data_b_q   <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      data_a_q   <= data_a_d;
      data_b_q   <= data_b_d;
      op_q       <= op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      overrun_q  <= overrun_d;
      timeout_q  <= timeout_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_A:  if (i_rx_done) state_d = WAIT_B;
      WAIT_B: begin
        if (i_rx_done)     state_d = WAIT_OP;
        else if (cnt_last) state_d = WAIT_A;
      end
      WAIT_OP: begin
        if (i_rx_done)     state_d = EXEC;
        else if (cnt_last) state_d = WAIT_A;
      end
      EXEC:    state_d = WAIT_TX;
      // The done strobe is only honoured once the request pulse is gone.
      WAIT_TX: if (i_tx_done && !tx_start_q) state_d = WAIT_A;
      default: state_d = WAIT_A;
    endcase
  end

  always_comb begin
    data_a_d   = data_a_q;
    data_b_d   = data_b_q;
    op_d       = op_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    overrun_d  = overrun_q;
    timeout_d  = 1'b0;
    cnt_d      = '0;
    unique case (state_q)
      WAIT_A: begin
        if (i_rx_done) data_a_d = i_rx_data;
      end
      WAIT_B: begin
        if (i_rx_done)     data_b_d  = i_rx_data;
        else if (cnt_last) timeout_d = 1'b1;
        else               cnt_d     = cnt_q + 1'b1;
      end
      WAIT_OP: begin
        if (i_rx_done)     op_d      = i_rx_data[NB_OP-1:0];
        else if (cnt_last) timeout_d = 1'b1;
        else               cnt_d     = cnt_q + 1'b1;
      end
      EXEC: begin
        tx_data_d  = i_alu_result;
        tx_start_d = 1'b1;
        if (i_rx_done) overrun_d = 1'b1;
      end
      WAIT_TX: begin
        if (i_rx_done) overrun_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_data_a   = data_a_q;
  assign o_data_b   = data_b_q;
  assign o_op       = op_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_overrun  = overrun_q;
  assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Bench for alu_uart_sequencer: directed frames, scoreboard of tx bytes.
// ALU is modelled as A+B (op 0x20) or A&B (op 0x24).
module tb_alu_uart_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_done;
  logic [7:0] alu_res;
  logic       tx_done;
  logic [7:0] data_a, data_b, tx_data;
  logic [5:0] op;
  logic       tx_start, overrun, timeout;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    alu_res = data_a + data_b;
    if (op == 6'h24) alu_res = data_a & data_b;
  end

  alu_uart_sequencer #(
    .NB_DATA(8), .NB_OP(6), .TIMEOUT(16), .NB_TIMEOUT(5)
  ) dut (
    .i_clk(clk),
    .i_reset(rst),
    .i_rx_data(rx_data),
    .i_rx_done(rx_done),
    .i_alu_result(alu_res),
    .i_tx_done(tx_done),
    .o_data_a(data_a),
    .o_data_b(data_b),
    .o_op(op),
    .o_tx_data(tx_data),
    .o_tx_start(tx_start),
    .o_overrun(overrun),
    .o_timeout(timeout)
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every tx request pops one expected byte and its cycle.
  always @(negedge clk) begin
    if (tx_start) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL tx_unexpected: got tx_start data 0x%0h, expected none",
                 tx_data);
      end else begin
        e = sb.pop_front();
        check("tx_data", tx_data, e.data);
        check("tx_latency", cyc, e.cyc);
      end
    end
  end

  // All tasks start and end at a falling edge.
  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic send_op(input logic [7:0] b, input logic [7:0] res);
    sb.push_back('{data: res, cyc: cyc + 2});
    send(b);
  endtask

  task automatic wait_start();
    bit seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_start) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_start: got no tx_start in 20 cycles, expected one");
    end
  endtask

  task automatic pulse_tx();
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  initial begin
    int i;
    int tcount;
    rst = 1'b1;
    rx_data = '0;
    rx_done = 1'b0;
    tx_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_a", data_a, 8'h00);
    check("rst_b", data_b, 8'h00);
    check("rst_op", op, 6'h00);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_tx_start", tx_start, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_timeout", timeout, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Basic frame
    send(8'h05);
    send(8'h03);
    send_op(8'h20, 8'h08);
    check("f1_a", data_a, 8'h05);
    check("f1_b", data_b, 8'h03);
    check("f1_op", op, 6'h20);
    wait_start();
    @(negedge clk);
    pulse_tx();

    // Back-to-back frame, first byte on the cycle after tx_done
    send(8'hFF);
    check("f2_a", data_a, 8'hFF);
    send(8'h01);
    check("f2_b", data_b, 8'h01);
    send_op(8'h20, 8'h00);
    wait_start();
    @(negedge clk);
    pulse_tx();

    // OP masking, tx_done during request ignored, overruns
    send(8'h07);
    send(8'h0C);
    send_op(8'hE4, 8'h04);
    check("f3_op_mask", op, 6'h24);
    wait_start();
    pulse_tx();
    send(8'h55);
    check("ovr_set", overrun, 1'b1);
    check("ovr_a_kept", data_a, 8'h07);
    rx_data = 8'h66;
    rx_done = 1'b1;
    tx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    tx_done = 1'b0;
    check("ovr_coincident", overrun, 1'b1);
    check("ovr_a_kept2", data_a, 8'h07);

    // Timeout after A only
    send(8'h11);
    i = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (timeout) begin
        i = k;
        break;
      end
    end
    check("to_delay", i, 16);
    @(negedge clk);
    check("to_one_pulse", timeout, 1'b0);
    check("to_a_kept", data_a, 8'h11);
    check("to_b_kept", data_b, 8'h0C);
    send(8'h01);
    send(8'h02);
    send_op(8'h20, 8'h03);
    wait_start();
    @(negedge clk);
    pulse_tx();

    // Byte on the terminal cycle is accepted
    send(8'h21);
    tcount = 0;
    repeat (15) begin
      @(negedge clk);
      if (timeout) tcount++;
    end
    send(8'h22);
    check("term_no_pulse_wait", tcount, 0);
    check("term_b", data_b, 8'h22);
    check("term_no_pulse", timeout, 1'b0);
    send_op(8'h20, 8'h43);
    wait_start();
    @(negedge clk);
    pulse_tx();
    check("ovr_sticky", overrun, 1'b1);

    // Asynchronous reset in WAIT_OP
    send(8'h33);
    send(8'h44);
    #2 rst = 1'b1;
    #1;
    check("arst_a", data_a, 8'h00);
    check("arst_b", data_b, 8'h00);
    check("arst_op", op, 6'h00);
    check("arst_tx_data", tx_data, 8'h00);
    check("arst_overrun", overrun, 1'b0);
    check("arst_tx_start", tx_start, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    send(8'h01);
    send(8'h01);
    send_op(8'h20, 8'h02);
    wait_start();
    @(negedge clk);
    pulse_tx();
    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end by 200000, expected earlier finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_uart_sequencer.md
# alu_uart_sequencer

Frame sequencer that drives the ALU operand/opcode registers from a byte stream and returns the ALU result as a byte. It replaces manual button loading: it consumes bytes from a UART receiver (A, then B, then OP), holds them on the ALU inputs, samples the combinational ALU result, and hands it to a UART transmitter with a start/done handshake. It sits between `uart_rx`/`uart_tx` and the `alu` instance inside the board top.

## Interface
- NB_DATA, 8, operand/result/byte width
- NB_OP, 6, opcode width (low NB_OP bits of the OP byte)
- TIMEOUT, 1_000_000, inter-byte timeout in clock cycles (>= 2)
- NB_TIMEOUT, 20, timeout counter width; must hold TIMEOUT

- i_clk  in  1  system clock, all logic on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_rx_data  in  NB_DATA  received byte, valid when i_rx_done
- i_rx_done  in  1  one-cycle strobe, byte available
- i_alu_result  in  NB_DATA  combinational ALU output
- i_tx_done  in  1  one-cycle strobe, transmitter finished a byte
- o_data_a  out  NB_DATA  operand A to ALU
- o_data_b  out  NB_DATA  operand B to ALU
- o_op  out  NB_OP  opcode to ALU
- o_tx_data  out  NB_DATA  byte to transmit, stable from o_tx_start until next frame
- o_tx_start  out  1  one-cycle request to transmitter
- o_overrun  out  1  sticky: byte arrived while not accepting
- o_timeout  out  1  one-cycle pulse: partial frame aborted

## Operation
- Reset (async, active-high): state WAIT_A; o_data_a, o_data_b, o_tx_data = 0; o_op = 0; o_tx_start, o_overrun, o_timeout = 0; timeout counter = 0.
- States: WAIT_A, WAIT_B, WAIT_OP, EXEC, WAIT_TX.
- WAIT_A: on i_rx_done, o_data_a <= i_rx_data, go WAIT_B. No timeout in WAIT_A.
- WAIT_B: on i_rx_done, o_data_b <= i_rx_data, go WAIT_OP.
- WAIT_OP: on i_rx_done, o_op <= i_rx_data[NB_OP-1:0] (upper bits discarded), go EXEC.
- EXEC: exactly one cycle; ALU settles on the new o_op. On leaving: o_tx_data <= i_alu_result, o_tx_start <= 1, go WAIT_TX.
- WAIT_TX: o_tx_start high only in first cycle; i_tx_done ignored while o_tx_start is high; first i_tx_done afterwards -> WAIT_A.
- Overrun: i_rx_done in EXEC or WAIT_TX -> byte discarded, o_overrun <= 1, held until reset. State flow unaffected.
- Timeout: in WAIT_B/WAIT_OP counter increments each cycle without i_rx_done, clears on entry and on every accepted byte. When counter reaches TIMEOUT-1 with no i_rx_done that cycle: go WAIT_A, o_timeout pulses one cycle, counter clears. Operand registers keep last values (not cleared). i_rx_done on the terminal cycle wins: byte accepted, no timeout.
- Operand registers change only on accepted bytes; ALU inputs are stable between frames.
- No transmit timeout: WAIT_TX waits indefinitely for i_tx_done.

## Timing
- All outputs registered; no combinational input-to-output paths.
- Byte strobe sampled at edge k -> corresponding register valid after edge k.
- OP strobe at edge k -> EXEC during cycle k..k+1 -> o_tx_start high and o_tx_data valid after edge k+1 (2-cycle latency from OP strobe to tx request).
- i_tx_done at edge m (o_tx_start low) -> WAIT_A after edge m; a byte strobing at edge m+1 is accepted as A.
- i_rx_done at edge m coincident with accepting i_tx_done -> overrun (still WAIT_TX at that edge), byte dropped.
- Reset asserted mid-frame: immediate return to reset values, pending tx request dropped.
- Throughput: one frame per 3 byte times + 1 cycle + transmit time.

## Test plan
- Basic frame: bytes 0x05, 0x03, 0x20 with bench ALU model result = A+B -> o_data_a=0x05, o_data_b=0x03, o_op=0x20, one o_tx_start pulse 2 cycles after OP strobe, o_tx_data=0x08; i_tx_done returns to WAIT_A.
- OP masking: OP byte 0xE4 -> o_op=0x24; upper bits ignored.
- Back-to-back frames: second frame 0xFF, 0x01, 0x20 right after i_tx_done -> o_tx_data=0x00 (model wraps), first frame operands overwritten in order.
- Overrun: byte 0x55 strobed during WAIT_TX -> o_overrun=1 and stays 1; next accepted byte after i_tx_done becomes A; 0x55 never appears on o_data_a.
- Timeout (TIMEOUT=16): send A=0x11 only, wait 16 cycles -> o_timeout single pulse, state WAIT_A, o_data_a still 0x11; new frame then completes normally. Byte on terminal cycle -> accepted, no pulse.
- Async reset mid-frame: assert i_reset in WAIT_OP without clock edge -> all outputs 0 immediately; no o_tx_start after release.
